// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// Instruction memory is read combinationally at inst_addr_o in the same cycle.
module if_fetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PROG_END = WIDTH'(44)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             freeze_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_addr_i,
    input  logic [WIDTH-1:0] instruction_i,
    output logic [WIDTH-1:0] inst_addr_o,
    output logic [WIDTH-1:0] if_id_pc_o,
    output logic [WIDTH-1:0] if_id_instruction_o,
    output logic             if_id_valid_o,
    output logic             halted_o
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    localparam logic [WIDTH-1:0] PcStep         = WIDTH'(4);
    localparam logic [WIDTH-1:0] ResetPcAligned = {RESET_PC[WIDTH-1:2], 2'b00};

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] if_id_pc_q;
    logic [WIDTH-1:0] if_id_instr_q;
    logic             if_id_valid_q;
    logic             halted_q;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] redirect_pc;
    logic             unused_addr_lsbs;

    // Wraps modulo 2^WIDTH; the carry is simply dropped.
    assign pc_plus4         = pc_q + PcStep;
    assign redirect_pc      = {branch_addr_i[WIDTH-1:2], 2'b00};
    assign unused_addr_lsbs = ^branch_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StBoot;
            pc_q          <= ResetPcAligned;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // Memory finishes loading this cycle; any redirect is ignored.
                    if_id_pc_q    <= '0;
                    if_id_instr_q <= '0;
                    if_id_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                    state_q       <= StRun;
                end
                StRun: begin
                    if (branch_taken_i) begin
                        pc_q          <= redirect_pc;
                        if_id_pc_q    <= '0;
                        if_id_instr_q <= '0;
                        if_id_valid_q <= 1'b0;
                        halted_q      <= 1'b0;
                    end else if (pc_q >= PROG_END) begin
                        // End of program wins over freeze.
                        if_id_pc_q    <= '0;
                        if_id_instr_q <= '0;
                        if_id_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                        state_q       <= StHalt;
                    end else if (!freeze_i) begin
                        pc_q          <= pc_plus4;
                        if_id_pc_q    <= pc_plus4;
                        if_id_instr_q <= instruction_i;
                        if_id_valid_q <= 1'b1;
                    end
                end
                StHalt: begin
                    if_id_pc_q    <= '0;
                    if_id_instr_q <= '0;
                    if_id_valid_q <= 1'b0;
                    if (branch_taken_i) begin
                        // A late branch resolving in the pipeline can restart the loop.
                        pc_q     <= redirect_pc;
                        halted_q <= 1'b0;
                        state_q  <= StRun;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    assign inst_addr_o         = pc_q;
    assign if_id_pc_o          = if_id_pc_q;
    assign if_id_instruction_o = if_id_instr_q;
    assign if_id_valid_o       = if_id_valid_q;
    assign halted_o            = halted_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table for the main trace plus
// hand-written sequences for reset, BOOT redirect and end-of-program under freeze.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instruction;
    logic [31:0] inst_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;

    int n_vec;
    int n_miss;

    if_fetch_stage #(
        .WIDTH   (32),
        .RESET_PC(32'h0),
        .PROG_END(32'd44)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .freeze_i           (freeze),
        .branch_taken_i     (branch_taken),
        .branch_addr_i      (branch_addr),
        .instruction_i      (instruction),
        .inst_addr_o        (inst_addr),
        .if_id_pc_o         (if_id_pc),
        .if_id_instruction_o(if_id_instruction),
        .if_id_valid_o      (if_id_valid),
        .halted_o           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00:  rom = 32'h80200006;
            32'h04:  rom = 32'h80400001;
            32'h08:  rom = 32'h80600001;
            32'h0C:  rom = 32'h80420001;
            32'h10:  rom = 32'h80000010;
            32'h14:  rom = 32'h80000014;
            32'h18:  rom = 32'h80840001;
            32'h1C:  rom = 32'h8000001C;
            32'h20:  rom = 32'h80000020;
            32'h24:  rom = 32'h80000024;
            32'h28:  rom = 32'h80000028;
            default: rom = 32'hDEADBEEF;
        endcase
    endfunction

    always_comb instruction = rom(inst_addr);

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        v;
        logic        h;
    } vec_t;

    vec_t vecs[$];

    // Apply inputs, clock once, then compare all outputs 1 time unit after the edge.
    task automatic step(input string name, input logic rst, input logic frz, input logic br,
                        input logic [31:0] baddr, input logic [31:0] e_addr,
                        input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_v,
                        input logic e_h);
        reset        = rst;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
        @(posedge clk);
        #1;
        n_vec++;
        if (inst_addr !== e_addr || if_id_pc !== e_pc || if_id_instruction !== e_ins ||
            if_id_valid !== e_v || halted !== e_h) begin
            n_miss++;
            $display("FAIL %s: got addr=%h pc=%h ins=%h v=%b h=%b, want addr=%h pc=%h ins=%h v=%b h=%b",
                     name, inst_addr, if_id_pc, if_id_instruction, if_id_valid, halted,
                     e_addr, e_pc, e_ins, e_v, e_h);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        reset        = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;

        //              rst   frz   br    baddr  addr   pc     ins           v     h
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h8, 32'h0, 32'h0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'h80200006, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 32'h8, 32'h80400001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h8, 32'h80400001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h8, 32'h80400001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'hC, 32'hC, 32'h80600001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h18, 32'h18, 32'h0, 32'h0,      1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h1C, 32'h1C, 32'h80840001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 32'h20, 32'h8000001C, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h24, 32'h24, 32'h80000020, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h28, 32'h28, 32'h80000024, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h2C, 32'h2C, 32'h80000028, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h2C, 32'h0, 32'h0,       1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h2C, 32'h0, 32'h0,       1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h2C, 32'h0, 32'h0,       1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hC, 32'hC, 32'h0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h10, 32'h10, 32'h80420001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h1B, 32'h18, 32'h0, 32'h0,      1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h1C, 32'h1C, 32'h80840001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 32'h0, 32'h0,     1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h0,       1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h4, 32'h4, 32'h0, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 32'h8, 32'h80400001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 32'hC, 32'hC, 32'h80600001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'hC, 32'hC, 32'h80600001, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].frz, vecs[i].br, vecs[i].baddr,
                 vecs[i].addr, vecs[i].pc, vecs[i].ins, vecs[i].v, vecs[i].h);
        end

        // Reset while running with a valid slot and a redirect pending.
        step("to_1c",      1'b0, 1'b0, 1'b1, 32'h1C, 32'h1C, 32'h0,  32'h0,        1'b0, 1'b0);
        step("at_20",      1'b0, 1'b0, 1'b0, 32'h0,  32'h20, 32'h20, 32'h8000001C, 1'b1, 1'b0);
        step("mid_reset",  1'b1, 1'b0, 1'b1, 32'h10, 32'h0,  32'h0,  32'h0,        1'b0, 1'b0);
        step("boot_br",    1'b0, 1'b0, 1'b1, 32'h18, 32'h0,  32'h0,  32'h0,        1'b0, 1'b0);
        step("post_boot",  1'b0, 1'b0, 1'b0, 32'h0,  32'h4,  32'h4,  32'h80200006, 1'b1, 1'b0);

        // End of program reached while frozen still halts.
        step("to_28",      1'b0, 1'b0, 1'b1, 32'h28, 32'h28, 32'h0,  32'h0,        1'b0, 1'b0);
        step("at_2c",      1'b0, 1'b0, 1'b0, 32'h0,  32'h2C, 32'h2C, 32'h80000028, 1'b1, 1'b0);
        step("frz_end",    1'b0, 1'b1, 1'b0, 32'h0,  32'h2C, 32'h0,  32'h0,        1'b0, 1'b1);

        // Reset out of HALT, held with other inputs active.
        step("halt_rst",   1'b1, 1'b1, 1'b1, 32'h8,  32'h0,  32'h0,  32'h0,        1'b0, 1'b0);
        step("rst_hold",   1'b1, 1'b0, 1'b1, 32'h14, 32'h0,  32'h0,  32'h0,        1'b0, 1'b0);
        step("boot2",      1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0,        1'b0, 1'b0);
        step("frz_first",  1'b0, 1'b1, 1'b0, 32'h0,  32'h0,  32'h0,  32'h0,        1'b0, 1'b0);
        step("run_first",  1'b0, 1'b0, 1'b0, 32'h0,  32'h4,  32'h4,  32'h80200006, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
